// File: rtl/mem_arbiter.sv
// Three-port arbiter (loader, instruction fetch, data) in front of one synchronous single-port memory.
// Latency: the grant is combinational in an IDLE cycle. Read data and rvalid follow in the next (BUSY) cycle.
// Backpressure: a requester holds req until it sees its gnt. At most one grant is issued every two cycles.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ld_*_i / ld_gnt_o, ld_rvalid_o loader port; always wins while it requests
//   if_*_i / if_gnt_o, if_rvalid_o instruction-fetch port, read-only
//   dm_*_i / dm_gnt_o, dm_rvalid_o data port
//   rdata_o, err_o                shared read data, and a pulse for an access that was misaligned or out of range
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i   memory side
module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [31:0]       ld_addr_i,
    input  logic [31:0]       ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,

    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,

    output logic [31:0]       rdata_o,
    output logic              err_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_IF,
        SRC_DM
    } src_e;

    state_e      state_q, state_d;
    // Set means the data port was served most recently, so fetch wins the next if/dm tie.
    logic        last_dm_q, last_dm_d;

    // Response owed in the BUSY cycle that follows a grant.
    logic        rsp_vld_q, rsp_vld_d;
    src_e        rsp_src_q, rsp_src_d;
    logic        rsp_ok_q,  rsp_ok_d;
    logic        err_q,     err_d;

    src_e        win;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_we;
    logic        win_ok;

    // Winner selection. Arbitration happens only in IDLE and never during reset.
    always_comb begin
        win = SRC_NONE;
        if (!rst_i && state_q == ST_IDLE) begin
            if (ld_req_i) begin
                win = SRC_LD;
            end else if (if_req_i && dm_req_i) begin
                win = last_dm_q ? SRC_IF : SRC_DM;
            end else if (if_req_i) begin
                win = SRC_IF;
            end else if (dm_req_i) begin
                win = SRC_DM;
            end
        end
    end

    // Mux the winner's request fields. The fetch port never writes.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        case (win)
            SRC_LD: begin
                win_addr  = ld_addr_i;
                win_wdata = ld_wdata_i;
                win_we    = ld_we_i;
            end
            SRC_IF: begin
                win_addr  = if_addr_i;
            end
            SRC_DM: begin
                win_addr  = dm_addr_i;
                win_wdata = dm_wdata_i;
                win_we    = dm_we_i;
            end
            default: ;
        endcase
    end

    // An access must be word aligned and must fall inside the 2^ADDR_W word window.
    assign win_ok = (win_addr[1:0] == 2'b00) && (win_addr[31:ADDR_W+2] == '0);

    // Grant and memory strobes are combinational in the winning cycle.
    always_comb begin
        ld_gnt_o    = (win == SRC_LD);
        if_gnt_o    = (win == SRC_IF);
        dm_gnt_o    = (win == SRC_DM);
        mem_en_o    = (win != SRC_NONE) && win_ok;
        mem_we_o    = mem_en_o && win_we;
        mem_addr_o  = mem_en_o ? win_addr[ADDR_W+1:2] : '0;
        mem_wdata_o = mem_we_o ? win_wdata : '0;
    end

    // Next-state logic and the response bookkeeping for the following cycle.
    always_comb begin
        state_d   = state_q;
        last_dm_d = last_dm_q;
        rsp_vld_d = 1'b0;
        rsp_src_d = SRC_NONE;
        rsp_ok_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win != SRC_NONE) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (win != SRC_NONE) begin
            // A write completes at grant. Only a read owes an rvalid, and a bad read returns zero data.
            rsp_vld_d = !win_we;
            rsp_src_d = win;
            rsp_ok_d  = win_ok;
            err_d     = !win_ok;
        end

        // Loader grants leave the round-robin pointer untouched.
        if (win == SRC_IF) begin
            last_dm_d = 1'b0;
        end else if (win == SRC_DM) begin
            last_dm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            last_dm_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_src_q <= SRC_NONE;
            rsp_ok_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_dm_q <= last_dm_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_src_q <= rsp_src_d;
            rsp_ok_q  <= rsp_ok_d;
            err_q     <= err_d;
        end
    end

    // The response flops are masked while reset is high. This makes a reset that lands in BUSY
    // discard the owed rvalid/err in that same cycle rather than one cycle later.
    assign ld_rvalid_o = !rst_i && rsp_vld_q && (rsp_src_q == SRC_LD);
    assign if_rvalid_o = !rst_i && rsp_vld_q && (rsp_src_q == SRC_IF);
    assign dm_rvalid_o = !rst_i && rsp_vld_q && (rsp_src_q == SRC_DM);
    assign err_o       = !rst_i && err_q;
    // The memory returns data one cycle after the read strobe, so rdata is steered rather than registered.
    assign rdata_o     = (!rst_i && rsp_vld_q && rsp_ok_q) ? mem_rdata_i : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of shared memory (1024 words).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ld_req/ld_we  input  1/1  loader port request / write-enable (highest priority).
REQ-005 ld_addr/ld_wdata  input  32/32  loader byte address / write data.
REQ-006 ld_gnt/ld_rvalid  output  1/1  loader grant pulse / read-data-valid pulse.
REQ-007 if_req  input  1  instruction-fetch read request (read-only port).
REQ-008 if_addr  input  32  fetch byte address.
REQ-009 if_gnt/if_rvalid  output  1/1  fetch grant pulse / read-data-valid pulse.
REQ-010 dm_req/dm_we  input  1/1  data-port request / write-enable.
REQ-011 dm_addr/dm_wdata  input  32/32  data byte address / write data.
REQ-012 dm_gnt/dm_rvalid  output  1/1  data grant pulse / read-data-valid pulse.
REQ-013 rdata  output  32  shared read data, meaningful only while some *_rvalid is high.
REQ-014 err  output  1  one-cycle pulse: granted access was misaligned or out of range.
REQ-015 mem_en/mem_we  output  1/1  memory access strobe / write strobe.
REQ-016 mem_addr  output  ADDR_W  word index = winner addr[ADDR_W+1:2].
REQ-017 mem_wdata  output  32  winner write data.
REQ-018 mem_rdata  input  32  synchronous memory read data, valid cycle after mem_en read.

Function
REQ-019 FSM states IDLE, BUSY; IDLE with any req -> BUSY; BUSY -> IDLE unconditionally; IDLE with no req stays IDLE.
REQ-020 Arbitration only in IDLE; winner selected combinationally from current req inputs.
REQ-021 Loader wins whenever ld_req=1; otherwise if/dm round-robin via 1-bit last-served pointer.
REQ-022 Round-robin: both if_req and dm_req high -> port not last served wins; pointer updated to winner on every if/dm grant; loader grants leave pointer unchanged.
REQ-023 In IDLE winning cycle: exactly one *_gnt high, combinational, same cycle; gnt never asserted in BUSY.
REQ-024 Valid access (addr[1:0]==0 and addr[31:ADDR_W+2]==0): mem_en=1, mem_we=winner we (0 for fetch), mem_addr/mem_wdata from winner, in grant cycle only.
REQ-025 Invalid access: gnt still asserted, mem_en=0, err pulses in following BUSY cycle; a read returns rvalid with rdata=0.
REQ-026 Read latency: winner *_rvalid high exactly in BUSY cycle following grant, rdata=mem_rdata (or 0 per REQ-025).
REQ-027 Write: completes at grant; no rvalid.
REQ-028 Throughput: at most one grant per 2 cycles; back-to-back requesters served on alternate cycles.
REQ-029 Requester holds req, we, addr, wdata stable until its gnt; deasserting req before gnt withdraws request with no side effect.
REQ-030 Requests arriving during BUSY wait; arbitrated in next IDLE cycle.
REQ-031 Outputs other than gnt/mem_* registered; at most one *_rvalid high per cycle.
REQ-032 No starvation: with if and dm both continuously requesting and ld_req low, grants strictly alternate.

Reset
REQ-033 reset=1: state IDLE, pointer = "fetch last served" (data wins first tie), all outputs 0, gnt/mem_en forced 0 regardless of req.
REQ-034 Reset during BUSY: pending rvalid and err discarded; no rvalid in cycle after reset released.
REQ-035 First grant possible in first cycle with reset low.

Verification
REQ-036 After reset, if_req and dm_req both high, dm_we=0, addrs 0x0/0x4 -> dm_gnt cycle 1, dm_rvalid cycle 2, if_gnt cycle 3, if_rvalid cycle 4.
REQ-037 ld_req write addr 0x10 data 0xDEADBEEF while if_req high -> ld_gnt, mem_we=1, mem_addr=4; then if read 0x10 returns rdata=0xDEADBEEF.
REQ-038 dm_req read addr 0x6 -> dm_gnt, mem_en=0, next cycle dm_rvalid=1, rdata=0, err=1.
REQ-039 dm_req addr 0x1000 (ADDR_W=10) -> out of range, same response as REQ-038.
REQ-040 if and dm requesting continuously for 20 cycles -> 10 grants alternating dm,if,dm,...; no gnt in BUSY cycles.
REQ-041 reset asserted in BUSY after read grant -> no rvalid, all outputs 0 next cycle; pending if_req re-granted after reset release.
